uart_regfile_fifo: RTL and testbench

- Parametrised next-generation UART CPU register file. It sits between the CPU-side register bus and the UART TX/RX cores.
- Adds TX and RX FIFOs with valid/ready handshakes, FIFO level registers, sticky overflow flags, and a maskable interrupt output.
- CONTROL is passed straight through to the UART core.

---
 rtl/uart_regfile_fifo_if.sv | 34 +++
 rtl/uart_regfile_fifo.sv | 122 ++++++++++++
 tb/tb_uart_regfile_fifo.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_regfile_fifo_if.sv
// Bus bundle between the CPU register port / UART cores and the register file.
// The slave modport is the register file; the master modport is its environment
// (CPU side plus the UART TX/RX cores).
interface uart_regfile_fifo_if #(
   parameter int WIDTH = 8
);
   logic             wr_en;
   logic [2:0]       wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             rd_en;
   logic [2:0]       rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] control;
   logic [WIDTH-1:0] uart_tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [WIDTH-1:0] uart_rx_data;
   logic             rx_valid;
   logic             busy;
   logic             done;
   logic             irq;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr,
      output tx_ready, uart_rx_data, rx_valid, busy, done,
      input  rd_data, control, uart_tx_data, tx_valid, irq
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
      input  tx_ready, uart_rx_data, rx_valid, busy, done,
      output rd_data, control, uart_tx_data, tx_valid, irq
   );
endinterface

// File: rtl/uart_regfile_fifo.sv
// UART CPU register file with TX/RX FIFOs, level registers, sticky W1C event
// flags and a maskable, registered interrupt.
module uart_regfile_fifo #(
   parameter int WIDTH    = 8,
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4
) (
   input logic              clk,
   input logic              arst_n,
   uart_regfile_fifo_if.slave bus
);
   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam logic [TX_AW:0] TX_FULL_LVL = (TX_AW + 1)'(TX_DEPTH);
   localparam logic [RX_AW:0] RX_FULL_LVL = (RX_AW + 1)'(RX_DEPTH);

   localparam logic [2:0] A_CONTROL = 3'd0;
   localparam logic [2:0] A_TXDATA  = 3'd1;
   localparam logic [2:0] A_STATUS  = 3'd2;
   localparam logic [2:0] A_RXDATA  = 3'd3;
   localparam logic [2:0] A_IRQEN   = 3'd4;
   localparam logic [2:0] A_IRQST   = 3'd5;
   localparam logic [2:0] A_RXLVL   = 3'd6;
   localparam logic [2:0] A_TXLVL   = 3'd7;

   logic [WIDTH-1:0] tx_mem [TX_DEPTH];
   logic [WIDTH-1:0] rx_mem [RX_DEPTH];
   logic [TX_AW-1:0] tx_wptr, tx_rptr;
   logic [RX_AW-1:0] rx_wptr, rx_rptr;
   logic [TX_AW:0]   tx_level;
   logic [RX_AW:0]   rx_level;

   logic [WIDTH-1:0] control_r, rd_r, rd_mux;
   logic [3:0]       irq_en;
   logic [2:0]       irq_stat, irq_set, irq_clr, irq_stat_nxt;
   logic             done_d, irq_r;

   logic tx_empty, tx_full, rx_empty, rx_full;
   logic tx_push_req, tx_push, tx_pop, tx_ovf;
   logic rx_pop, rx_push, rx_ovf;

   assign tx_empty = (tx_level == '0);
   assign tx_full  = (tx_level == TX_FULL_LVL);
   assign rx_empty = (rx_level == '0);
   assign rx_full  = (rx_level == RX_FULL_LVL);

   // A same-cycle pop frees the slot, so a push into a full FIFO survives it.
   assign tx_pop      = !tx_empty && bus.tx_ready;
   assign tx_push_req = bus.wr_en && (bus.wr_addr == A_TXDATA);
   assign tx_push     = tx_push_req && (!tx_full || tx_pop);
   assign tx_ovf      = tx_push_req && tx_full && !tx_pop;

   // Reading RX_DATA while empty is a no-op on the FIFO.
   assign rx_pop  = bus.rd_en && (bus.rd_addr == A_RXDATA) && !rx_empty;
   assign rx_push = bus.rx_valid && (!rx_full || rx_pop);
   assign rx_ovf  = bus.rx_valid && rx_full && !rx_pop;

   // Set beats clear when both hit the same bit in one cycle.
   assign irq_set      = {tx_ovf, rx_ovf, bus.done && !done_d};
   assign irq_clr      = (bus.wr_en && (bus.wr_addr == A_IRQST)) ? bus.wr_data[2:0] : 3'b000;
   assign irq_stat_nxt = (irq_stat & ~irq_clr) | irq_set;

   assign bus.rd_data      = rd_r;
   assign bus.control      = control_r;
   assign bus.irq          = irq_r;
   assign bus.tx_valid     = !tx_empty;
   assign bus.uart_tx_data = tx_empty ? '0 : tx_mem[tx_rptr];

   // Read mux over pre-edge state; unmapped and write-only locations read 0.
   always_comb begin
      rd_mux = '0;
      case (bus.rd_addr)
         A_CONTROL: rd_mux = control_r;
         A_STATUS:  rd_mux[5:0] = {rx_full, rx_empty, tx_full, tx_empty, bus.busy, bus.done};
         A_RXDATA:  if (!rx_empty) rd_mux = rx_mem[rx_rptr];
         A_IRQEN:   rd_mux[3:0] = irq_en;
         A_IRQST:   rd_mux[2:0] = irq_stat;
         A_RXLVL:   rd_mux[RX_AW:0] = rx_level;
         A_TXLVL:   rd_mux[TX_AW:0] = tx_level;
         default:   rd_mux = '0;
      endcase
   end

   // FIFO storage; contents need no reset because the pointers and levels do.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wptr] <= bus.wr_data;
      if (rx_push) rx_mem[rx_wptr] <= bus.uart_rx_data;
   end

   // Registers, FIFO pointers/levels, event flags and the interrupt output.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         control_r <= '0;
         irq_en    <= '0;
         irq_stat  <= '0;
         done_d    <= 1'b0;
         rd_r      <= '0;
         irq_r     <= 1'b0;
         tx_wptr   <= '0;
         tx_rptr   <= '0;
         tx_level  <= '0;
         rx_wptr   <= '0;
         rx_rptr   <= '0;
         rx_level  <= '0;
      end else begin
         if (bus.wr_en && (bus.wr_addr == A_CONTROL)) control_r <= bus.wr_data;
         if (bus.wr_en && (bus.wr_addr == A_IRQEN))   irq_en    <= bus.wr_data[3:0];
         irq_stat <= irq_stat_nxt;
         done_d   <= bus.done;
         if (bus.rd_en) rd_r <= rd_mux;
         irq_r <= (|(irq_stat & irq_en[2:0])) | (irq_en[3] & !rx_empty);

         if (tx_push) tx_wptr <= tx_wptr + TX_AW'(1);
         if (tx_pop)  tx_rptr <= tx_rptr + TX_AW'(1);
         tx_level <= tx_level + (TX_AW + 1)'(tx_push) - (TX_AW + 1)'(tx_pop);

         if (rx_push) rx_wptr <= rx_wptr + RX_AW'(1);
         if (rx_pop)  rx_rptr <= rx_rptr + RX_AW'(1);
         rx_level <= rx_level + (RX_AW + 1)'(rx_push) - (RX_AW + 1)'(rx_pop);
      end
   end
endmodule

// File: tb/tb_uart_regfile_fifo.sv
// Directed, table-driven bench for uart_regfile_fifo (WIDTH=8, depths 4).
// Each table row is one clock cycle of stimulus plus the values expected just
// after that edge; -1 in an expectation field means "not checked this cycle".
module tb_uart_regfile_fifo;
   localparam int W = 8;

   logic clk = 1'b0;
   logic arst_n;
   int   n_checks = 0;
   int   n_err    = 0;

   uart_regfile_fifo_if #(.WIDTH(W)) bus ();

   uart_regfile_fifo #(.WIDTH(W), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int wr, wa, wd, rd, ra, rxv, rxd, txr, dn, bsy;
      int e_rd, e_irq, e_txv, e_txd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int wr, int wa, int wd, int rd, int ra,
                               int rxv, int rxd, int txr, int dn, int bsy,
                               int e_rd, int e_irq, int e_txv, int e_txd);
      vec_t v;
      v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra;
      v.rxv = rxv; v.rxd = rxd; v.txr = txr; v.dn = dn; v.bsy = bsy;
      v.e_rd = e_rd; v.e_irq = e_irq; v.e_txv = e_txv; v.e_txd = e_txd;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.wr_en        = v.wr[0];
      bus.wr_addr      = v.wa[2:0];
      bus.wr_data      = W'(v.wd);
      bus.rd_en        = v.rd[0];
      bus.rd_addr      = v.ra[2:0];
      bus.rx_valid     = v.rxv[0];
      bus.uart_rx_data = W'(v.rxd);
      bus.tx_ready     = v.txr[0];
      bus.done         = v.dn[0];
      bus.busy         = v.bsy[0];
   endtask

   task automatic apply(input vec_t v, input string tag);
      drive(v);
      @(posedge clk);
      #1;
      if (v.e_rd  >= 0) chk({tag, " rd_data"},      int'(bus.rd_data),      v.e_rd);
      if (v.e_irq >= 0) chk({tag, " irq"},          int'(bus.irq),          v.e_irq);
      if (v.e_txv >= 0) chk({tag, " tx_valid"},     int'(bus.tx_valid),     v.e_txv);
      if (v.e_txd >= 0) chk({tag, " uart_tx_data"}, int'(bus.uart_tx_data), v.e_txd);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " rd_data"},      int'(bus.rd_data),      0);
      chk({tag, " irq"},          int'(bus.irq),          0);
      chk({tag, " tx_valid"},     int'(bus.tx_valid),     0);
      chk({tag, " uart_tx_data"}, int'(bus.uart_tx_data), 0);
      chk({tag, " control"},      int'(bus.control),      0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t idle;
      idle = mk(0,0,0, 0,0, 0,0, 0,0,0, -1,-1,-1,-1);

      // ---- reset map and register basics ----
      for (int a = 0; a < 8; a++)
         vecs.push_back(mk(0,0,0, 1,a, 0,0, 0,0,0, (a == 2) ? 'h14 : 0, 0,0,0));
      vecs.push_back(mk(1,0,'h3C, 0,0, 0,0, 0,0,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    1,0, 0,0, 0,0,0, 'h3C,0,0,0));
      vecs.push_back(mk(1,4,'hFF, 0,0, 0,0, 0,0,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    1,4, 0,0, 0,0,0, 'h0F,0,0,0));
      vecs.push_back(mk(1,4,'h00, 0,0, 0,0, 0,0,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    1,2, 0,0, 0,0,1, 'h16,0,0,0));
      vecs.push_back(mk(1,6,'hFF, 0,0, 0,0, 0,0,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    1,6, 0,0, 0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,2,'hFF, 0,0, 0,0, 0,0,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    1,2, 0,0, 0,0,0, 'h14,0,0,0));
      vecs.push_back(mk(1,3,'h77, 0,0, 0,0, 0,0,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    1,3, 0,0, 0,0,0, 0,0,0,0));
      vecs.push_back(mk(0,0,0,    1,6, 0,0, 0,0,0, 0,0,0,0));
      vecs.push_back(mk(0,0,0,    1,1, 0,0, 0,0,0, 0,0,0,0));

      // ---- TX FIFO: push two, then drain ----
      vecs.push_back(mk(1,1,'hA5, 0,0, 0,0, 0,0,0, -1,0,1,'hA5));
      vecs.push_back(mk(1,1,'h5A, 0,0, 0,0, 0,0,0, -1,0,1,'hA5));
      vecs.push_back(mk(0,0,0,    1,7, 0,0, 0,0,0, 2,0,1,'hA5));
      vecs.push_back(mk(0,0,0,    0,0, 0,0, 1,0,0, -1,0,1,'h5A));
      vecs.push_back(mk(0,0,0,    0,0, 0,0, 1,0,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    1,7, 0,0, 0,0,0, 0,0,0,0));

      // ---- TX FIFO: fill, push-with-pop when full, overflow ----
      for (int i = 1; i <= 4; i++)
         vecs.push_back(mk(1,1,i, 0,0, 0,0, 0,0,0, -1,0,1,1));
      vecs.push_back(mk(0,0,0,    1,7, 0,0, 0,0,0, 4,0,1,1));
      vecs.push_back(mk(0,0,0,    1,2, 0,0, 0,0,0, 'h18,0,1,1));
      vecs.push_back(mk(1,1,'h05, 0,0, 0,0, 1,0,0, -1,0,1,2));
      vecs.push_back(mk(0,0,0,    1,5, 0,0, 0,0,0, 0,0,1,2));
      vecs.push_back(mk(0,0,0,    1,7, 0,0, 0,0,0, 4,0,1,2));
      vecs.push_back(mk(1,1,'h06, 0,0, 0,0, 0,0,0, -1,0,1,2));
      vecs.push_back(mk(0,0,0,    1,5, 0,0, 0,0,0, 'h04,0,1,2));
      vecs.push_back(mk(1,5,'h04, 0,0, 0,0, 0,0,0, -1,0,1,2));
      vecs.push_back(mk(0,0,0,    1,5, 0,0, 0,0,0, 0,0,1,2));
      vecs.push_back(mk(0,0,0,    0,0, 0,0, 1,0,0, -1,0,1,3));
      vecs.push_back(mk(0,0,0,    0,0, 0,0, 1,0,0, -1,0,1,4));
      vecs.push_back(mk(0,0,0,    0,0, 0,0, 1,0,0, -1,0,1,5));
      vecs.push_back(mk(0,0,0,    0,0, 0,0, 1,0,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    1,7, 0,0, 0,0,0, 0,0,0,0));

      // ---- RX FIFO: overflow then drain past empty ----
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0,0,0, 0,0, 1,'h11 + i, 0,0,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    1,6, 0,0, 0,0,0, 4,0,0,0));
      vecs.push_back(mk(0,0,0,    1,2, 0,0, 0,0,0, 'h24,0,0,0));
      vecs.push_back(mk(0,0,0,    1,5, 0,0, 0,0,0, 'h02,0,0,0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0,0,0, 1,3, 0,0, 0,0,0, 'h11 + i,0,0,0));
      vecs.push_back(mk(0,0,0,    1,3, 0,0, 0,0,0, 0,0,0,0));
      vecs.push_back(mk(0,0,0,    1,6, 0,0, 0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,5,'h02, 0,0, 0,0, 0,0,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    1,5, 0,0, 0,0,0, 0,0,0,0));

      // ---- RX FIFO: push into full with same-cycle pop; push+pop when empty ----
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0,0,0, 0,0, 1,'h21 + i, 0,0,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    1,3, 1,'h25, 0,0,0, 'h21,0,0,0));
      vecs.push_back(mk(0,0,0,    1,5, 0,0, 0,0,0, 0,0,0,0));
      vecs.push_back(mk(0,0,0,    1,6, 0,0, 0,0,0, 4,0,0,0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0,0,0, 1,3, 0,0, 0,0,0, 'h22 + i,0,0,0));
      vecs.push_back(mk(0,0,0,    1,6, 0,0, 0,0,0, 0,0,0,0));
      vecs.push_back(mk(0,0,0,    1,3, 1,'h26, 0,0,0, 0,0,0,0));
      vecs.push_back(mk(0,0,0,    1,6, 0,0, 0,0,0, 1,0,0,0));
      vecs.push_back(mk(0,0,0,    1,3, 0,0, 0,0,0, 'h26,0,0,0));

      // ---- done edge, W1C, set-beats-clear, irq latency ----
      vecs.push_back(mk(1,4,'h01, 0,0, 0,0, 0,0,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    0,0, 0,0, 0,1,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    1,5, 0,0, 0,1,0, 'h01,1,0,0));
      vecs.push_back(mk(1,5,'h01, 1,5, 0,0, 0,1,0, 'h01,1,0,0));
      vecs.push_back(mk(0,0,0,    1,5, 0,0, 0,1,0, 0,0,0,0));
      vecs.push_back(mk(0,0,0,    0,0, 0,0, 0,0,0, -1,0,0,0));
      vecs.push_back(mk(1,5,'h01, 0,0, 0,0, 0,1,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    1,5, 0,0, 0,1,0, 'h01,1,0,0));
      vecs.push_back(mk(1,5,'h01, 0,0, 0,0, 0,0,0, -1,1,0,0));
      vecs.push_back(mk(0,0,0,    1,5, 0,0, 0,0,0, 0,0,0,0));
      vecs.push_back(mk(1,4,'h00, 0,0, 0,0, 0,0,0, -1,0,0,0));

      // ---- rx-not-empty interrupt ----
      vecs.push_back(mk(1,4,'h08, 0,0, 0,0, 0,0,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    0,0, 1,'h3C, 0,0,0, -1,0,0,0));
      vecs.push_back(mk(0,0,0,    0,0, 0,0, 0,0,0, -1,1,0,0));
      vecs.push_back(mk(0,0,0,    1,3, 0,0, 0,0,0, 'h3C,1,0,0));
      vecs.push_back(mk(0,0,0,    0,0, 0,0, 0,0,0, 'h3C,0,0,0));
      vecs.push_back(mk(1,4,'h00, 0,0, 0,0, 0,0,0, -1,0,0,0));

      // Power-on reset
      arst_n = 1'b0;
      drive(idle);
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("por");
      arst_n = 1'b1;

      foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

      // Mid-operation reset with TX_LEVEL=3, data in RX and irq asserted
      apply(mk(1,0,'h55, 0,0, 0,0, 0,0,0, -1,-1,-1,-1), "mr_ctl");
      apply(mk(1,1,'h81, 0,0, 0,0, 0,0,0, -1,-1,1,'h81), "mr_tx0");
      apply(mk(1,1,'h82, 0,0, 0,0, 0,0,0, -1,-1,1,'h81), "mr_tx1");
      apply(mk(1,1,'h83, 0,0, 0,0, 0,0,0, -1,-1,1,'h81), "mr_tx2");
      apply(mk(0,0,0,    1,7, 0,0, 0,0,0, 3,-1,1,'h81), "mr_txlvl");
      apply(mk(1,4,'h08, 0,0, 0,0, 0,0,0, -1,-1,-1,-1), "mr_ien");
      apply(mk(0,0,0,    0,0, 1,'h99, 0,0,0, -1,0,-1,-1), "mr_rx");
      apply(mk(0,0,0,    1,0, 0,0, 0,0,0, 'h55,1,1,'h81), "mr_rdctl");
      chk("mr control before reset", int'(bus.control), 'h55);

      arst_n = 1'b0;
      drive(mk(1,1,'hEE, 1,3, 1,'h77, 1,1,1, -1,-1,-1,-1));
      @(posedge clk);
      #1;
      check_all_zero("mid_rst");
      arst_n = 1'b1;

      apply(mk(0,0,0, 1,2, 0,0, 0,0,0, 'h14,0,0,0), "post_status");
      apply(mk(0,0,0, 1,7, 0,0, 0,0,0, 0,0,0,0),    "post_txlvl");
      apply(mk(0,0,0, 1,6, 0,0, 0,0,0, 0,0,0,0),    "post_rxlvl");
      apply(mk(0,0,0, 1,5, 0,0, 0,0,0, 0,0,0,0),    "post_irqst");
      apply(mk(0,0,0, 1,4, 0,0, 0,0,0, 0,0,0,0),    "post_irqen");
      apply(mk(0,0,0, 1,0, 0,0, 0,0,0, 0,0,0,0),    "post_ctl");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
